// File: rtl/axi_dbg_pkg.sv
// Shared definitions for the AXI4-Lite debug master: FSM states, command
// bytes, response status bytes and the AXI response decode helper.
// Also provides a default for `CEP_AXI_ADDR_WIDTH when the platform does not.

`ifndef CEP_AXI_ADDR_WIDTH
`define CEP_AXI_ADDR_WIDTH 32
`endif

package axi_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_SEND
    } dbg_state_e;

    // Command opcodes (first byte of a frame)
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;

    // Status byte, first byte of every response
    localparam logic [7:0] STS_OKAY    = 8'h00;
    localparam logic [7:0] STS_ERR     = 8'h01;
    localparam logic [7:0] STS_TIMEOUT = 8'h02;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Any non-OKAY AXI response collapses to a single error status.
    function automatic logic [7:0] resp_status(input logic [1:0] resp);
        return (resp == AXI_RESP_OKAY) ? STS_OKAY : STS_ERR;
    endfunction

endpackage

// File: rtl/axi_lite_dbg_master_if.sv
// AXI4-Lite bundle with Master/Slave modports.

interface AXI_LITE #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) ();

    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;

    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;

    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;

    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;

    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport Master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport Slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface

// File: rtl/axi_lite_dbg_master_tx_ser.sv
// axi_dbg_tx_ser: shifts out a 1- or 5-byte response, MSB byte first,
// over a valid/ready byte stream. o_done pulses on acceptance of the last byte.

module axi_dbg_tx_ser (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_load,
    input  logic        i_len5,
    input  logic [39:0] i_bytes,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_done
);

    logic [39:0] r_shift;
    logic [2:0]  r_left;
    logic        r_valid;
    logic        w_accept;

    assign w_accept   = r_valid && i_tx_ready;
    assign o_done     = w_accept && (r_left == 3'd0);
    assign o_tx_data  = r_shift[39:32];
    assign o_tx_valid = r_valid;

    // Load a response, then advance one byte per accepted transfer; data only
    // moves on acceptance so it is held steady across sink stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift <= '0;
            r_left  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_bytes;
            r_left  <= i_len5 ? 3'd4 : 3'd0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_shift <= {r_shift[31:0], 8'h00};
            if (r_left == 3'd0)
                r_valid <= 1'b0;
            else
                r_left <= r_left - 3'd1;
        end
    end

endmodule

// File: rtl/axi_lite_dbg_master.sv
// axi_lite_dbg_master: turns a byte-stream command protocol into single
// AXI4-Lite reads/writes and streams back a status (+ read data) response.
// Optional feature macro: AXI_DBG_RX_TIMEOUT_EN (abort stalled partial commands).

`ifndef CEP_AXI_ADDR_WIDTH
`define CEP_AXI_ADDR_WIDTH 32
`endif

module axi_lite_dbg_master
    import axi_dbg_pkg::*;
#(
    parameter int ADDR_WIDTH     = `CEP_AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    AXI_LITE.Master    master
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axi_lite_dbg_master: only DATA_WIDTH=32 is supported");
    end
    if (ADDR_WIDTH != `CEP_AXI_ADDR_WIDTH) begin : g_bad_addr_width
        $error("axi_lite_dbg_master: ADDR_WIDTH must match CEP_AXI_ADDR_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("axi_lite_dbg_master: TIMEOUT_CYCLES must be at least 1");
    end

    dbg_state_e  r_state;
    dbg_state_e  w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_cnt;
    logic        r_is_wr;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_rx_ready;
    logic        w_rx_fire;
    logic        w_tmo;
    logic        w_wr_done;
    logic        w_ld;
    logic        w_ld_len5;
    logic [39:0] w_ld_bytes;
    logic        w_tx_done;

    assign w_rx_ready = (r_state == ST_IDLE) || (r_state == ST_GET_ADDR) ||
                        (r_state == ST_GET_DATA);
    assign rx_ready_o = w_rx_ready && !rst_i;
    assign w_rx_fire  = rx_valid_i && rx_ready_o;
    assign busy_o     = (r_state != ST_IDLE);

    // AW and W are launched together; each drops independently once accepted.
    assign master.awaddr  = ADDR_WIDTH'(r_addr);
    assign master.awprot  = 3'b000;
    assign master.awvalid = (r_state == ST_WR_REQ) && !r_aw_done;
    assign master.wdata   = DATA_WIDTH'(r_wdata);
    assign master.wstrb   = '1;
    assign master.wvalid  = (r_state == ST_WR_REQ) && !r_w_done;
    assign master.bready  = (r_state == ST_WR_RESP);
    assign master.araddr  = ADDR_WIDTH'(r_addr);
    assign master.arprot  = 3'b000;
    assign master.arvalid = (r_state == ST_RD_REQ);
    assign master.rready  = (r_state == ST_RD_RESP);

    assign w_wr_done = (r_aw_done || master.awready) && (r_w_done || master.wready);

`ifdef AXI_DBG_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_in_get;

    assign w_in_get = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
    assign w_tmo    = w_in_get && !w_rx_fire &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive byte-less cycles inside a partial command.
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_in_get || w_rx_fire)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state decode and response loading into the serializer.
    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_ld_len5   = 1'b0;
        w_ld_bytes  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire && (rx_data_i == CMD_READ || rx_data_i == CMD_WRITE))
                    w_state_nxt = ST_GET_ADDR;
            end
            ST_GET_ADDR: begin
                if (w_rx_fire && r_cnt == 2'd3)
                    w_state_nxt = r_is_wr ? ST_GET_DATA : ST_RD_REQ;
                else if (w_tmo) begin
                    w_state_nxt = ST_SEND;
                    w_ld        = 1'b1;
                    w_ld_bytes  = {STS_TIMEOUT, 32'h0};
                end
            end
            ST_GET_DATA: begin
                if (w_rx_fire && r_cnt == 2'd3)
                    w_state_nxt = ST_WR_REQ;
                else if (w_tmo) begin
                    w_state_nxt = ST_SEND;
                    w_ld        = 1'b1;
                    w_ld_bytes  = {STS_TIMEOUT, 32'h0};
                end
            end
            ST_WR_REQ: begin
                if (w_wr_done)
                    w_state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (master.bvalid) begin
                    w_state_nxt = ST_SEND;
                    w_ld        = 1'b1;
                    w_ld_bytes  = {resp_status(master.bresp), 32'h0};
                end
            end
            ST_RD_REQ: begin
                if (master.arready)
                    w_state_nxt = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (master.rvalid) begin
                    w_state_nxt = ST_SEND;
                    w_ld        = 1'b1;
                    w_ld_len5   = 1'b1;
                    w_ld_bytes  = {resp_status(master.rresp), 32'(master.rdata)};
                end
            end
            ST_SEND: begin
                if (w_tx_done)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command field assembly (MSB first) and AW/W completion tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_is_wr   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_rx_fire) begin
                case (r_state)
                    ST_IDLE: begin
                        r_is_wr <= (rx_data_i == CMD_WRITE);
                        r_cnt   <= 2'd0;
                    end
                    ST_GET_ADDR: begin
                        r_addr <= {r_addr[23:0], rx_data_i};
                        r_cnt  <= r_cnt + 2'd1;
                    end
                    ST_GET_DATA: begin
                        r_wdata <= {r_wdata[23:0], rx_data_i};
                        r_cnt   <= r_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (r_state == ST_WR_REQ) begin
                if (master.awvalid && master.awready) r_aw_done <= 1'b1;
                if (master.wvalid && master.wready)   r_w_done  <= 1'b1;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

    axi_dbg_tx_ser u_tx_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_ld),
        .i_len5     (w_ld_len5),
        .i_bytes    (w_ld_bytes),
        .o_tx_data  (tx_data_o),
        .o_tx_valid (tx_valid_o),
        .i_tx_ready (tx_ready_i),
        .o_done     (w_tx_done)
    );

endmodule
